// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, hex font
// (segments a..g on bits 6..0, active-low) and the digit-index width helper.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [0:15][6:0] HEX_FONT = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sevenseg_hex_font.sv
// Combinational hex-to-segment decoder (active-low a..g).
module sevenseg_hex_font
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_FONT[hex_i];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with per-frame shadow capture,
// leading-zero suppression, PWM brightness and a guard slot. Optional blink via SEVENSEG_BLINK_EN.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV_W    = 13,
  parameter int BRIGHT_W = 4
`ifdef SEVENSEG_BLINK_EN
  , parameter int BLINK_W = 6
`endif
)
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
`ifdef SEVENSEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    pre_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] sh_digits_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic [DIGITS-1:0]   sh_blank_q;
  logic                sh_lz_q;
  logic [BRIGHT_W-1:0] sh_bright_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_tick_q;

`ifdef SEVENSEG_BLINK_EN
  logic [BLINK_W-1:0]  blink_cnt_q;
  logic [DIGITS-1:0]   sh_blink_mask_q;
  logic                sh_blink_ph_q;
`endif

  logic                load;
  logic [DIGITS-1:0]   lz_bits;
  logic                zero_run;
  int                  pos;
  logic [3:0]          sel_nib;
  logic [6:0]          font_seg;
  logic                blink_dark;
  logic                dark;
  logic                suppressed;
  logic                lit;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   an_d;

  assign load = (pre_q == '0) && (idx_q == '0);

  // lz_bits uses the same bit order as dp_in/blank_in (MSB = leftmost digit).
  always_comb begin
    zero_run = 1'b1;
    lz_bits  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (sh_digits_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      lz_bits[DIGITS-1-k] = sh_lz_q && zero_run && (k != DIGITS - 1);
    end
  end

  always_comb begin
    pos     = DIGITS - 1 - int'(idx_q);
    sel_nib = sh_digits_q[4*pos +: 4];
  end

  sevenseg_hex_font u_font (
    .hex_i (sel_nib),
    .seg_o (font_seg)
  );

`ifdef SEVENSEG_BLINK_EN
  assign blink_dark = sh_blink_ph_q && sh_blink_mask_q[pos];
`else
  assign blink_dark = 1'b0;
`endif

  // A suppressed zero with its dp set keeps the anode on so the dp stays visible.
  always_comb begin
    suppressed = lz_bits[pos];
    dark       = sh_blank_q[pos] || blink_dark || (suppressed && !sh_dp_q[pos]);
    lit        = !dark && (pre_q != '0) && (pre_q[DIV_W-1 -: BRIGHT_W] <= sh_bright_q);
    seg_d      = (dark || suppressed) ? SEG_BLANK : font_seg;
    dp_d       = dark ? 1'b1 : !sh_dp_q[pos];
    an_d       = '1;
    if (lit) an_d[pos] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q        <= '0;
      idx_q        <= '0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
`ifdef SEVENSEG_BLINK_EN
      blink_cnt_q     <= '0;
      sh_blink_mask_q <= '0;
      sh_blink_ph_q   <= 1'b0;
`endif
    end else begin
      pre_q <= pre_q + 1'b1;
      if (pre_q == '1) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (load) begin
        sh_digits_q <= digits_in;
        sh_dp_q     <= dp_in;
        sh_blank_q  <= blank_in;
        sh_lz_q     <= lz_en;
        sh_bright_q <= bright;
`ifdef SEVENSEG_BLINK_EN
        // The frame just starting uses the pre-increment count's MSB.
        blink_cnt_q     <= blink_cnt_q + 1'b1;
        sh_blink_mask_q <= blink_mask;
        sh_blink_ph_q   <= blink_cnt_q[BLINK_W-1];
`endif
      end
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= load;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIGITS=4, DIV_W=4, BRIGHT_W=2.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blank_in = 4'b0000;
  logic        lz_en = 1'b0;
  logic [1:0]  bright = 2'd3;
`ifdef SEVENSEG_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_1234 [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
  logic [6:0] seg_5678 [4] = '{7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
  logic [3:0] an_on    [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .DIGITS   (4),
    .DIV_W    (4),
    .BRIGHT_W (2)
`ifdef SEVENSEG_BLINK_EN
    , .BLINK_W (2)
`endif
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .bright     (bright),
`ifdef SEVENSEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // After return, the next rising edge is the first (loading) edge after release.
  task automatic do_reset;
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0; bright = 2'd3;
    do_reset();
    repeat (40) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg i=%0d got=%b exp=%b", i, seg, 7'h7F); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp i=%0d got=%b exp=1", i, dp); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an i=%0d got=%b exp=1111", i, an); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick i=%0d got=%b exp=0", i, frame_tick); end
    end
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got=%b exp=1", frame_tick); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL first_an got=%b exp=1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL first_seg got=%b exp=%b", seg, 7'h7F); end
    @(posedge clk); #1;
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL second_tick got=%b exp=0", frame_tick); end
    checks++; if (seg !== 7'b1001111) begin errors++; $display("FAIL first_digit_seg got=%b exp=1001111", seg); end
    checks++; if (an !== 4'b0111) begin errors++; $display("FAIL first_digit_an got=%b exp=0111", an); end
  endtask

  task automatic test_normal_scan;
    int on_cnt;
    logic [3:0] e_an;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0; bright = 2'd3;
    do_reset();
    on_cnt = 0;
    for (int n = 0; n < 140; n++) begin
      @(posedge clk); #1;
      checks++; if (frame_tick !== (n % 64 == 0)) begin errors++; $display("FAIL normal_tick n=%0d got=%b exp=%b", n, frame_tick, (n % 64 == 0)); end
      if (n >= 1) begin
        e_an = ((n % 16) == 0) ? 4'b1111 : an_on[(n / 16) % 4];
        checks++; if (seg !== seg_1234[(n / 16) % 4]) begin errors++; $display("FAIL normal_seg n=%0d got=%b exp=%b", n, seg, seg_1234[(n / 16) % 4]); end
        checks++; if (an !== e_an) begin errors++; $display("FAIL normal_an n=%0d got=%b exp=%b", n, an, e_an); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL normal_dp n=%0d got=%b exp=1", n, dp); end
        if (n >= 64 && n < 80 && an == 4'b0111) on_cnt++;
      end
    end
    checks++; if (on_cnt !== 15) begin errors++; $display("FAIL normal_slot0_on_cycles got=%0d exp=15", on_cnt); end
  endtask

  task automatic test_lz;
    logic [6:0] e_seg [4];
    logic [3:0] e_dp;
    logic [3:0] e_on;
    logic [3:0] e_an;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        digits_in = 16'h0007; dp_in = 4'b0100;
        e_seg = '{7'h7F, 7'h7F, 7'h7F, 7'b0001111}; e_dp = 4'b0100; e_on = 4'b0101;
      end else begin
        digits_in = 16'h0000; dp_in = 4'b0000;
        e_seg = '{7'h7F, 7'h7F, 7'h7F, 7'b0000001}; e_dp = 4'b0000; e_on = 4'b0001;
      end
      blank_in = 4'b0000; lz_en = 1'b1; bright = 2'd3;
      do_reset();
      @(posedge clk);
      for (int n = 1; n <= 64; n++) begin
        @(posedge clk); #1;
        e_an = (e_on[3 - (n / 16) % 4] && (n % 16) != 0) ? an_on[(n / 16) % 4] : 4'b1111;
        checks++; if (seg !== e_seg[(n / 16) % 4]) begin errors++; $display("FAIL lz%0d_seg n=%0d got=%b exp=%b", c, n, seg, e_seg[(n / 16) % 4]); end
        checks++; if (an !== e_an) begin errors++; $display("FAIL lz%0d_an n=%0d got=%b exp=%b", c, n, an, e_an); end
        checks++; if (dp !== !e_dp[3 - (n / 16) % 4]) begin errors++; $display("FAIL lz%0d_dp n=%0d got=%b exp=%b", c, n, dp, !e_dp[3 - (n / 16) % 4]); end
      end
    end
    lz_en = 1'b0; dp_in = 4'b0000;
  endtask

  task automatic test_bright_blank;
    int on_cnt;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0100; lz_en = 1'b0; bright = 2'd0;
    do_reset();
    @(posedge clk);
    on_cnt = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if ((n / 16) % 4 == 1) begin
        e_seg = 7'h7F; e_an = 4'b1111;
      end else begin
        e_seg = seg_1234[(n / 16) % 4];
        e_an = ((n % 16) >= 1 && (n % 16) <= 3) ? an_on[(n / 16) % 4] : 4'b1111;
      end
      checks++; if (seg !== e_seg) begin errors++; $display("FAIL dim_seg n=%0d got=%b exp=%b", n, seg, e_seg); end
      checks++; if (an !== e_an) begin errors++; $display("FAIL dim_an n=%0d got=%b exp=%b", n, an, e_an); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL dim_dp n=%0d got=%b exp=1", n, dp); end
      if (n < 16 && an == 4'b0111) on_cnt++;
    end
    checks++; if (on_cnt !== 3) begin errors++; $display("FAIL dim_slot0_on_cycles got=%0d exp=3", on_cnt); end
    blank_in = 4'b0000; bright = 2'd3;
  endtask

  task automatic test_shadow_load;
    logic [6:0] e_seg;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0; bright = 2'd3;
    do_reset();
    @(posedge clk);
    for (int n = 1; n <= 128; n++) begin
      @(posedge clk); #1;
      e_seg = (n <= 64) ? seg_1234[(n / 16) % 4] : seg_5678[(n / 16) % 4];
      checks++; if (seg !== e_seg) begin errors++; $display("FAIL shadow_seg n=%0d got=%b exp=%b", n, seg, e_seg); end
      if (n == 20) digits_in = 16'h5678;
    end
  endtask

`ifdef SEVENSEG_BLINK_EN
  task automatic test_blink;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       d0_dark;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0; bright = 2'd3;
    blink_mask = 4'b1000;
    do_reset();
    @(posedge clk);
    for (int n = 1; n <= 320; n++) begin
      @(posedge clk); #1;
      d0_dark = (((n - 1) / 64) % 4) >= 2;
      if ((n / 16) % 4 == 0 && d0_dark) begin
        e_seg = 7'h7F; e_an = 4'b1111;
      end else begin
        e_seg = seg_1234[(n / 16) % 4];
        e_an = ((n % 16) == 0) ? 4'b1111 : an_on[(n / 16) % 4];
      end
      checks++; if (seg !== e_seg) begin errors++; $display("FAIL blink_seg n=%0d got=%b exp=%b", n, seg, e_seg); end
      checks++; if (an !== e_an) begin errors++; $display("FAIL blink_an n=%0d got=%b exp=%b", n, an, e_an); end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_normal_scan();
    test_lz();
    test_bright_blank();
    test_shadow_load();
`ifdef SEVENSEG_BLINK_EN
    test_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
